// File: rtl/am_pkg.sv
// Shared constants, FSM state type and helpers for the AM query scheduler.
package am_pkg;

    localparam int HV_DIM          = 80;
    localparam int SEQ_CYCLE_COUNT = 10;
    localparam int DIMS_PER_CC     = HV_DIM / SEQ_CYCLE_COUNT;
    localparam int NUM_CLASSES     = 26;
    localparam int CLASS_W         = 5;
    localparam int CNT_W           = 11;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT,
        CAPTURE,
        FINISH
    } sched_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/am_query_fifo.sv
// Small power-of-two FIFO buffering {hv, class, last} query entries.
module am_query_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        // a full FIFO refuses the push even when a pop frees a slot
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/am_query_scheduler.sv
// Buffers encoder queries and issues them one at a time to the AM,
// timing the fixed AM latency and reporting per-sample results.
module am_query_scheduler #(
    parameter int HV_DIM     = 80,
    parameter int FIFO_DEPTH = 4,
    parameter int AM_CYCLES  = 13
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         testing_hdc_model,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [HV_DIM-1:0]            in_query_hv,
    input  logic [am_pkg::CLASS_W-1:0]   in_correct_class,
    input  logic                         in_last,
    output logic                         am_en,
    output logic                         am_start_querying,
    output logic                         am_testing_hdc_model,
    output logic                         am_testing_dataset_finished,
    output logic [HV_DIM-1:0]            am_query_hv,
    output logic [am_pkg::CLASS_W-1:0]   am_correct_class,
    input  logic [am_pkg::CLASS_W-1:0]   am_class_inference,
    output logic                         res_valid,
    output logic [am_pkg::CLASS_W-1:0]   res_class,
    output logic                         res_correct,
    output logic [am_pkg::CNT_W-1:0]     sample_count,
    output logic                         busy,
    output logic                         done
);

    import am_pkg::*;

    localparam int EW = HV_DIM + CLASS_W + 1;
    localparam int TW = (AM_CYCLES > 2) ? $clog2(AM_CYCLES) : 1;

    sched_state_t       state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [HV_DIM-1:0]  hv_q, hv_d;
    logic [CLASS_W-1:0] cls_q, cls_d;
    logic               last_q, last_d;
    logic               start_q, start_d;
    logic               fin_q, fin_d;
    logic               done_q, done_d;
    logic               rv_q, rv_d;
    logic [CLASS_W-1:0] rcls_q, rcls_d;
    logic               rcor_q, rcor_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               clr_cnt_q, clr_cnt_d;
    logic               test_q, test_d;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [EW-1:0]      fifo_dout;

    assign fifo_push = in_valid && in_ready;
    assign fifo_pop  = en && (state_q == LOAD);

    am_query_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({in_query_hv, in_correct_class, in_last}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        hv_d      = hv_q;
        cls_d     = cls_q;
        last_d    = last_q;
        start_d   = start_q;
        fin_d     = fin_q;
        done_d    = done_q;
        rv_d      = rv_q;
        rcls_d    = rcls_q;
        rcor_d    = rcor_q;
        cnt_d     = cnt_q;
        clr_cnt_d = clr_cnt_q;
        test_d    = testing_hdc_model;
        // with en low every pulse is held so the AM sees it once enabled
        if (en) begin
            start_d = 1'b0;
            fin_d   = 1'b0;
            done_d  = 1'b0;
            rv_d    = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    {hv_d, cls_d, last_d} = fifo_dout;
                    state_d = ISSUE;
                end
                ISSUE: begin
                    start_d = 1'b1;
                    timer_d = TW'(AM_CYCLES - 1);
                    state_d = WAIT;
                end
                WAIT: begin
                    timer_d = timer_q - 1'b1;
                    if (timer_q == TW'(1)) begin
                        state_d = CAPTURE;
                    end
                end
                CAPTURE: begin
                    rv_d      = 1'b1;
                    rcls_d    = am_class_inference;
                    rcor_d    = (am_class_inference == cls_q);
                    cnt_d     = clr_cnt_q ? CNT_W'(1) : sat_inc(cnt_q);
                    clr_cnt_d = 1'b0;
                    state_d   = last_q ? FINISH : IDLE;
                end
                FINISH: begin
                    fin_d     = 1'b1;
                    done_d    = 1'b1;
                    clr_cnt_d = 1'b1;
                    state_d   = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            hv_q      <= '0;
            cls_q     <= '0;
            last_q    <= 1'b0;
            start_q   <= 1'b0;
            fin_q     <= 1'b0;
            done_q    <= 1'b0;
            rv_q      <= 1'b0;
            rcls_q    <= '0;
            rcor_q    <= 1'b0;
            cnt_q     <= '0;
            clr_cnt_q <= 1'b0;
            test_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            hv_q      <= hv_d;
            cls_q     <= cls_d;
            last_q    <= last_d;
            start_q   <= start_d;
            fin_q     <= fin_d;
            done_q    <= done_d;
            rv_q      <= rv_d;
            rcls_q    <= rcls_d;
            rcor_q    <= rcor_d;
            cnt_q     <= cnt_d;
            clr_cnt_q <= clr_cnt_d;
            test_q    <= test_d;
        end
    end

    // in_ready stays low while reset is held, then follows the FIFO
    assign in_ready                    = !fifo_full && !rst;
    assign am_en                       = en;
    assign am_start_querying           = start_q;
    assign am_testing_hdc_model        = test_q;
    assign am_testing_dataset_finished = fin_q;
    assign am_query_hv                 = hv_q;
    assign am_correct_class            = cls_q;
    assign res_valid                   = rv_q;
    assign res_class                   = rcls_q;
    assign res_correct                 = rcor_q;
    assign sample_count                = cnt_q;
    assign busy                        = (state_q != IDLE) || !fifo_empty;
    assign done                        = done_q;

endmodule

// File: tb/tb_am_query_scheduler.sv
// Directed bench for am_query_scheduler: vector table plus corner sequences.
module tb_am_query_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        testing_hdc_model;
    logic        in_valid;
    logic        in_ready;
    logic [79:0] in_query_hv;
    logic [4:0]  in_correct_class;
    logic        in_last;
    logic        am_en;
    logic        am_start_querying;
    logic        am_testing_hdc_model;
    logic        am_testing_dataset_finished;
    logic [79:0] am_query_hv;
    logic [4:0]  am_correct_class;
    logic [4:0]  am_class_inference;
    logic        res_valid;
    logic [4:0]  res_class;
    logic        res_correct;
    logic [10:0] sample_count;
    logic        busy;
    logic        done;

    logic [4:0]  am_inf;
    logic        echo;

    assign am_class_inference = echo ? am_correct_class : am_inf;

    always #5 clk = ~clk;

    am_query_scheduler #(
        .HV_DIM     (80),
        .FIFO_DEPTH (4),
        .AM_CYCLES  (13)
    ) dut (
        .clk                         (clk),
        .rst                         (rst),
        .en                          (en),
        .testing_hdc_model           (testing_hdc_model),
        .in_valid                    (in_valid),
        .in_ready                    (in_ready),
        .in_query_hv                 (in_query_hv),
        .in_correct_class            (in_correct_class),
        .in_last                     (in_last),
        .am_en                       (am_en),
        .am_start_querying           (am_start_querying),
        .am_testing_hdc_model        (am_testing_hdc_model),
        .am_testing_dataset_finished (am_testing_dataset_finished),
        .am_query_hv                 (am_query_hv),
        .am_correct_class            (am_correct_class),
        .am_class_inference          (am_class_inference),
        .res_valid                   (res_valid),
        .res_class                   (res_class),
        .res_correct                 (res_correct),
        .sample_count                (sample_count),
        .busy                        (busy),
        .done                        (done)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    int          st_cyc[$];
    int          rv_cyc[$];
    int          dn_cyc[$];
    logic [4:0]  rv_cls[$];
    logic        rv_cor[$];
    logic [10:0] rv_cnt[$];
    logic [79:0] rv_hv[$];
    bit          st_p, rv_p, dn_p;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (am_start_querying && !st_p) st_cyc.push_back(cyc);
        if (res_valid && !rv_p) begin
            rv_cyc.push_back(cyc);
            rv_cls.push_back(res_class);
            rv_cor.push_back(res_correct);
            rv_cnt.push_back(sample_count);
            rv_hv.push_back(am_query_hv);
        end
        if (done && !dn_p) dn_cyc.push_back(cyc);
        if (done || am_testing_dataset_finished)
            chk("done_eq_finished", done, am_testing_dataset_finished);
        st_p = am_start_querying;
        rv_p = res_valid;
        dn_p = done;
    end

    task automatic clearq();
        st_cyc.delete();
        rv_cyc.delete();
        dn_cyc.delete();
        rv_cls.delete();
        rv_cor.delete();
        rv_cnt.delete();
        rv_hv.delete();
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [79:0] hv, input logic [4:0] c,
                        input logic l, output int t);
        in_valid         = 1'b1;
        in_query_hv      = hv;
        in_correct_class = c;
        in_last          = l;
        @(posedge clk);
        #1;
        t        = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20 && busy; k++) wait_cyc(1);
        chk("idle", busy, 1'b0);
    endtask

    typedef struct {
        logic [4:0]  cls;
        logic [4:0]  am;
        logic        last;
        logic [4:0]  e_cls;
        logic        e_cor;
        logic [10:0] e_cnt;
    } vec_t;

    vec_t        vt[6];
    logic [15:0] tag;
    logic [79:0] hv;
    int          t, t2;
    int          k;

    initial begin
        vt[0] = '{5'd7,  5'd7,  1'b0, 5'd7,  1'b1, 11'd1};
        vt[1] = '{5'd3,  5'd12, 1'b1, 5'd12, 1'b0, 11'd2};
        vt[2] = '{5'd20, 5'd20, 1'b0, 5'd20, 1'b1, 11'd1};
        vt[3] = '{5'd25, 5'd0,  1'b0, 5'd0,  1'b0, 11'd2};
        vt[4] = '{5'd9,  5'd9,  1'b1, 5'd9,  1'b1, 11'd3};
        vt[5] = '{5'd0,  5'd0,  1'b0, 5'd0,  1'b1, 11'd1};

        rst = 1'b1;
        en = 1'b0;
        testing_hdc_model = 1'b0;
        in_valid = 1'b0;
        in_query_hv = '0;
        in_correct_class = '0;
        in_last = 1'b0;
        am_inf = '0;
        echo = 1'b0;

        wait_cyc(2);
        chk("reset_outputs",
            {in_ready, am_start_querying, am_testing_hdc_model,
             am_testing_dataset_finished, am_query_hv, am_correct_class,
             res_valid, res_class, res_correct, sample_count, busy, done},
            '0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", in_ready, 1'b1);

        en = 1'b1;
        testing_hdc_model = 1'b1;
        wait_cyc(2);
        chk("am_en_follows_en", am_en, 1'b1);
        chk("testing_registered", am_testing_hdc_model, 1'b1);

        for (int i = 0; i < 6; i++) begin
            clearq();
            am_inf = vt[i].am;
            tag = 16'hA000 + 16'(i);
            hv = {5{tag}};
            push(hv, vt[i].cls, vt[i].last, t);
            for (k = 0; k < 40 && rv_cyc.size() == 0; k++) wait_cyc(1);
            chk("vec_res_seen", rv_cyc.size(), 1);
            if (rv_cyc.size() > 0 && st_cyc.size() > 0) begin
                chk("vec_start_lat", st_cyc[0] - t, 3);
                chk("vec_res_lat", rv_cyc[0] - t, 16);
                chk("vec_class", rv_cls[0], vt[i].e_cls);
                chk("vec_correct", rv_cor[0], vt[i].e_cor);
                chk("vec_count", rv_cnt[0], vt[i].e_cnt);
                chk("vec_hv", rv_hv[0], hv);
            end
            wait_cyc(3);
            chk("vec_done_cnt", dn_cyc.size(), vt[i].last ? 1 : 0);
            if (vt[i].last && dn_cyc.size() > 0 && rv_cyc.size() > 0)
                chk("vec_done_lat", dn_cyc[0] - rv_cyc[0], 1);
            wait_idle();
        end

        // FIFO fill with en low, then release
        clearq();
        echo = 1'b1;
        en = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tag = 16'hB000 + 16'(i);
            push({5{tag}}, 5'(i), 1'b0, t);
        end
        chk("fifo_full_ready", in_ready, 1'b0);
        chk("fifo_full_busy", busy, 1'b1);
        en = 1'b1;
        for (k = 0; k < 10; k++) begin
            if (in_ready) break;
            wait_cyc(1);
        end
        chk("fifo_ready_after_load", k, 2);
        push({5{16'hB005}}, 5'd5, 1'b0, t);
        for (k = 0; k < 130 && rv_cyc.size() < 5; k++) wait_cyc(1);
        chk("fifo_res_cnt", rv_cyc.size(), 5);
        chk("fifo_start_cnt", st_cyc.size(), 5);
        for (int i = 0; i < rv_cyc.size(); i++) begin
            chk("fifo_order", rv_cls[i], 5'(i + 1));
            chk("fifo_count", rv_cnt[i], 11'(i + 2));
            if (i > 0) chk("fifo_spacing", rv_cyc[i] - rv_cyc[i-1], 16);
        end
        wait_idle();

        // en low for 5 cycles in WAIT
        clearq();
        push({5{16'hC00B}}, 5'd11, 1'b0, t);
        wait_cyc(6);
        en = 1'b0;
        wait_cyc(5);
        en = 1'b1;
        for (k = 0; k < 40 && rv_cyc.size() == 0; k++) wait_cyc(1);
        chk("stall_res_seen", rv_cyc.size(), 1);
        if (rv_cyc.size() > 0) begin
            chk("stall_res_lat", rv_cyc[0] - t, 21);
            chk("stall_class", rv_cls[0], 5'd11);
        end
        chk("stall_start_once", st_cyc.size(), 1);
        wait_idle();

        // en low while the start pulse is up
        clearq();
        push({5{16'hC00D}}, 5'd13, 1'b0, t);
        wait_cyc(3);
        chk("pulse_up", am_start_querying, 1'b1);
        en = 1'b0;
        wait_cyc(3);
        chk("pulse_held", am_start_querying, 1'b1);
        en = 1'b1;
        wait_cyc(1);
        chk("pulse_dropped", am_start_querying, 1'b0);
        for (k = 0; k < 40 && rv_cyc.size() == 0; k++) wait_cyc(1);
        chk("hold_res_seen", rv_cyc.size(), 1);
        if (rv_cyc.size() > 0) chk("hold_res_lat", rv_cyc[0] - t, 19);
        chk("hold_start_once", st_cyc.size(), 1);
        wait_idle();

        // reset mid-WAIT with two queued
        clearq();
        push({5{16'hD001}}, 5'd1, 1'b0, t);
        push({5{16'hD002}}, 5'd2, 1'b0, t2);
        push({5{16'hD003}}, 5'd3, 1'b1, t2);
        wait_cyc(5);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_outputs",
            {in_ready, am_start_querying, am_testing_hdc_model,
             am_testing_dataset_finished, am_query_hv, am_correct_class,
             res_valid, res_class, res_correct, sample_count, done},
            '0);
        chk("rst_busy", busy, 1'b0);
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(30);
        chk("rst_no_result", rv_cyc.size(), 0);
        chk("rst_no_done", dn_cyc.size(), 0);
        chk("rst_one_start", st_cyc.size(), 1);
        chk("rst_busy_after", busy, 1'b0);
        chk("rst_ready_after", in_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
